// File: rtl/ball_physics_engine.sv
// Ball kinematics for one player's half-field: X stepping, gravity, wall bounce,
// paddle return, speed levels and valid/ready ball exchange with the opponent board.
module ball_physics_engine #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int Y_MIN       = 20,
  parameter int X_STEP      = 8,
  parameter int SERVE_X     = 20,
  parameter int EDGE_MARGIN = 20,
  parameter int GRAV_PERIOD = 4,
  parameter int BASE_TICKS  = 270000,
  parameter int MAX_LVL     = 4,
  parameter int GW          = 2
) (
  input  logic          clk_25MHZ,
  input  logic          reset_n,
  input  logic          upscale,
  input  logic          new_game,
  input  logic          paddle_hit,
  input  logic [9:0]    hit_speed,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [9:0]    rx_y,
  input  logic [7:0]    rx_vy,
  input  logic [GW-1:0] rx_grav,
  input  logic [2:0]    rx_lvl,
  input  logic          rx_win,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [9:0]    tx_y,
  output logic [7:0]    tx_vy,
  output logic [GW-1:0] tx_grav,
  output logic [2:0]    tx_lvl,
  output logic          tx_lose,
  output logic [9:0]    ball_x,
  output logic [9:0]    ball_y,
  output logic          moving_right,
  output logic          is_idle,
  output logic          game_over,
  output logic          you_win,
  output logic [7:0]    score
);

  typedef enum logic [2:0] {IDLE, RUN_R, RUN_L, HANDOFF, LOSE_TX, OVER} state_t;

  localparam int TW = $clog2(BASE_TICKS + 1);
  localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);

  state_t state, state_n;
  logic [9:0] x_n, y_n;
  logic signed [7:0] vy, vy_n;
  logic [GW-1:0] grav, grav_n;
  logic [2:0] lvl, lvl_n;
  logic [TW-1:0] tick, tick_n;
  logic [7:0] score_n;
  logic win_n;

  logic [10:0] x_max;
  logic [9:0] y_max;
  logic [TW-1:0] ticks, last_tick;
  logic step;

  logic signed [7:0] vy_g, vy_s;
  logic [GW-1:0] grav_s;
  logic signed [11:0] y_sum;
  logic [9:0] y_s;

  function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sd127 : -v;
  endfunction

  function automatic logic [2:0] clamp_lvl(input logic [9:0] v);
    if (v == 10'd0) return 3'd1;
    if (v > 10'(MAX_LVL)) return 3'(MAX_LVL);
    return v[2:0];
  endfunction

  assign x_max     = upscale ? 11'(H_RES) : 11'(H_RES / 2);
  assign y_max     = upscale ? 10'(V_RES - 1) : 10'(V_RES / 2 - 1);
  // Higher speed levels halve the step period; a period below one clock degrades to every clock.
  assign ticks     = TW'(BASE_TICKS >> (lvl - 3'd1));
  assign last_tick = (ticks > TW'(1)) ? ticks - TW'(1) : '0;
  assign step      = (tick >= last_tick);

  // Gravity and vertical bounce for one step; the bounce negates the gravity-updated velocity.
  always_comb begin
    vy_g   = vy;
    grav_s = grav + GW'(1);
    if (grav == GW'(GRAV_PERIOD - 1)) begin
      vy_g   = (vy == 8'sd127) ? vy : vy + 8'sd1;
      grav_s = '0;
    end
    y_sum = $signed({2'b00, ball_y}) + $signed({{4{vy[7]}}, vy});
    y_s   = y_sum[9:0];
    vy_s  = vy_g;
    if (y_sum >= $signed({2'b00, y_max})) begin
      y_s  = y_max;
      vy_s = neg_sat(vy_g);
    end else if (y_sum <= Y_MIN_S) begin
      y_s  = 10'(Y_MIN);
      vy_s = neg_sat(vy_g);
    end
  end

  always_comb begin
    state_n = state;
    x_n     = ball_x;
    y_n     = ball_y;
    vy_n    = vy;
    grav_n  = grav;
    lvl_n   = lvl;
    tick_n  = tick;
    score_n = score;
    win_n   = you_win;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_win) begin
            win_n = 1'b1;
          end else begin
            x_n     = 10'(SERVE_X);
            y_n     = (rx_y > y_max) ? y_max : rx_y;
            vy_n    = rx_vy;
            grav_n  = rx_grav;
            lvl_n   = clamp_lvl({7'd0, rx_lvl});
            tick_n  = '0;
            win_n   = 1'b0;
            state_n = RUN_R;
          end
        end
      end
      RUN_R: begin
        if (paddle_hit) begin
          lvl_n   = clamp_lvl(hit_speed);
          tick_n  = '0;
          score_n = (score == 8'hFF) ? score : score + 8'd1;
          state_n = RUN_L;
        end else if ({1'b0, ball_x} >= x_max - 11'(EDGE_MARGIN)) begin
          state_n = LOSE_TX;
        end else if (step) begin
          x_n    = ball_x + 10'(X_STEP);
          y_n    = y_s;
          vy_n   = vy_s;
          grav_n = grav_s;
          tick_n = '0;
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      RUN_L: begin
        if (ball_x == 10'd0) begin
          state_n = HANDOFF;
        end else if (step) begin
          x_n    = (ball_x < 10'(X_STEP)) ? 10'd0 : ball_x - 10'(X_STEP);
          y_n    = y_s;
          vy_n   = vy_s;
          grav_n = grav_s;
          tick_n = '0;
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      HANDOFF: if (tx_ready) state_n = IDLE;
      LOSE_TX: if (tx_ready) state_n = OVER;
      OVER: begin
        if (new_game) begin
          score_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHZ) begin
    if (!reset_n) begin
      state   <= IDLE;
      ball_x  <= 10'd10;
      ball_y  <= 10'd80;
      vy      <= -8'sd3;
      grav    <= '0;
      lvl     <= 3'd1;
      tick    <= '0;
      score   <= '0;
      you_win <= 1'b0;
    end else begin
      state   <= state_n;
      ball_x  <= x_n;
      ball_y  <= y_n;
      vy      <= vy_n;
      grav    <= grav_n;
      lvl     <= lvl_n;
      tick    <= tick_n;
      score   <= score_n;
      you_win <= win_n;
    end
  end

  // The outgoing packet is taken straight from the held registers, so it cannot change while waiting.
  assign rx_ready     = (state == IDLE);
  assign is_idle      = (state == IDLE);
  assign moving_right = (state == RUN_R);
  assign tx_valid     = (state == HANDOFF) || (state == LOSE_TX);
  assign tx_lose      = (state == LOSE_TX);
  assign game_over    = (state == LOSE_TX) || (state == OVER);
  assign tx_y         = ball_y;
  assign tx_vy        = vy;
  assign tx_grav      = grav;
  assign tx_lvl       = lvl;

endmodule

// File: tb/tb_ball_physics_engine.sv
// Self-checking bench: an integer model of the ball rules is compared every cycle,
// with directed scenarios and literal expectations pinning key points.
module tb_ball_physics_engine;

  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int Y_MIN       = 20;
  localparam int X_STEP      = 8;
  localparam int SERVE_X     = 20;
  localparam int EDGE_MARGIN = 20;
  localparam int GRAV_PERIOD = 4;
  localparam int BASE_TICKS  = 16;
  localparam int MAX_LVL     = 4;
  localparam int GW          = 2;

  localparam int MD_IDLE    = 0;
  localparam int MD_RIGHT   = 1;
  localparam int MD_LEFT    = 2;
  localparam int MD_HANDOFF = 3;
  localparam int MD_LOSE    = 4;
  localparam int MD_OVER    = 5;

  logic clk_25MHZ;
  logic reset_n;
  logic upscale;
  logic new_game;
  logic paddle_hit;
  logic [9:0] hit_speed;
  logic rx_valid;
  logic rx_ready;
  logic [9:0] rx_y;
  logic [7:0] rx_vy;
  logic [GW-1:0] rx_grav;
  logic [2:0] rx_lvl;
  logic rx_win;
  logic tx_valid;
  logic tx_ready;
  logic [9:0] tx_y;
  logic [7:0] tx_vy;
  logic [GW-1:0] tx_grav;
  logic [2:0] tx_lvl;
  logic tx_lose;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic moving_right;
  logic is_idle;
  logic game_over;
  logic you_win;
  logic [7:0] score;

  int n_checks;
  int n_fail;
  logic check_en;

  int m_mode, m_x, m_y, m_vy, m_grav, m_lvl, m_tick, m_score, m_win;

  ball_physics_engine #(
    .H_RES(H_RES), .V_RES(V_RES), .Y_MIN(Y_MIN), .X_STEP(X_STEP), .SERVE_X(SERVE_X),
    .EDGE_MARGIN(EDGE_MARGIN), .GRAV_PERIOD(GRAV_PERIOD), .BASE_TICKS(BASE_TICKS),
    .MAX_LVL(MAX_LVL), .GW(GW)
  ) dut (
    .clk_25MHZ(clk_25MHZ), .reset_n(reset_n), .upscale(upscale), .new_game(new_game),
    .paddle_hit(paddle_hit), .hit_speed(hit_speed), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_y(rx_y), .rx_vy(rx_vy), .rx_grav(rx_grav), .rx_lvl(rx_lvl), .rx_win(rx_win),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_y(tx_y), .tx_vy(tx_vy), .tx_grav(tx_grav),
    .tx_lvl(tx_lvl), .tx_lose(tx_lose), .ball_x(ball_x), .ball_y(ball_y),
    .moving_right(moving_right), .is_idle(is_idle), .game_over(game_over),
    .you_win(you_win), .score(score)
  );

  initial clk_25MHZ = 1'b0;
  always #20 clk_25MHZ = ~clk_25MHZ;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int clampLvl(input int v);
    if (v < 1) return 1;
    if (v > MAX_LVL) return MAX_LVL;
    return v;
  endfunction

  // Reference model: the ball rules in plain integer arithmetic, advanced on every rising edge.
  always @(posedge clk_25MHZ) begin : model
    int md, x, y, vy, gr, lv, tk, sc, wn, xmax, ymax, period, ny, dir;
    md = m_mode; x = m_x; y = m_y; vy = m_vy; gr = m_grav;
    lv = m_lvl; tk = m_tick; sc = m_score; wn = m_win;
    dir = 0;
    if (!reset_n) begin
      md = MD_IDLE; x = 10; y = 80; vy = -3; gr = 0; lv = 1; tk = 0; sc = 0; wn = 0;
    end else begin
      xmax = upscale ? H_RES : H_RES / 2;
      ymax = (upscale ? V_RES : V_RES / 2) - 1;
      period = BASE_TICKS / (1 << (lv - 1));
      if (period < 1) period = 1;
      case (md)
        MD_IDLE: begin
          if (rx_valid) begin
            if (rx_win) wn = 1;
            else begin
              x = SERVE_X;
              y = (int'(rx_y) < ymax) ? int'(rx_y) : ymax;
              vy = int'($signed(rx_vy));
              gr = int'(rx_grav);
              lv = clampLvl(int'(rx_lvl));
              tk = 0; wn = 0; md = MD_RIGHT;
            end
          end
        end
        MD_RIGHT: begin
          if (paddle_hit) begin
            lv = clampLvl(int'(hit_speed));
            tk = 0;
            sc = (sc < 255) ? sc + 1 : 255;
            md = MD_LEFT;
          end else if (x >= xmax - EDGE_MARGIN) md = MD_LOSE;
          else if (tk == period - 1) dir = 1;
          else tk = tk + 1;
        end
        MD_LEFT: begin
          if (x == 0) md = MD_HANDOFF;
          else if (tk == period - 1) dir = -1;
          else tk = tk + 1;
        end
        MD_HANDOFF: if (tx_ready) md = MD_IDLE;
        MD_LOSE:    if (tx_ready) md = MD_OVER;
        MD_OVER: begin
          if (new_game) begin sc = 0; md = MD_IDLE; end
        end
        default: md = MD_IDLE;
      endcase
      if (dir != 0) begin
        ny = y + vy;
        if (gr == GRAV_PERIOD - 1) begin
          vy = (vy + 1 > 127) ? 127 : vy + 1;
          gr = 0;
        end else gr = (gr + 1) % (1 << GW);
        if (ny >= ymax) begin
          y = ymax; vy = (vy == -128) ? 127 : -vy;
        end else if (ny <= Y_MIN) begin
          y = Y_MIN; vy = (vy == -128) ? 127 : -vy;
        end else y = ny;
        if (dir > 0) x = x + X_STEP;
        else x = (x - X_STEP < 0) ? 0 : x - X_STEP;
        tk = 0;
      end
    end
    m_mode <= md; m_x <= x; m_y <= y; m_vy <= vy; m_grav <= gr;
    m_lvl <= lv; m_tick <= tk; m_score <= sc; m_win <= wn;
  end

  // Every falling edge, all outputs are held against the model.
  always @(negedge clk_25MHZ) begin
    if (check_en) begin
      checkOutput("cmp_ball_x", int'(ball_x), m_x);
      checkOutput("cmp_ball_y", int'(ball_y), m_y);
      checkOutput("cmp_score", int'(score), m_score);
      checkOutput("cmp_you_win", int'(you_win), m_win);
      checkOutput("cmp_is_idle", int'(is_idle), int'(m_mode == MD_IDLE));
      checkOutput("cmp_rx_ready", int'(rx_ready), int'(m_mode == MD_IDLE));
      checkOutput("cmp_moving_right", int'(moving_right), int'(m_mode == MD_RIGHT));
      checkOutput("cmp_game_over", int'(game_over), int'(m_mode == MD_LOSE || m_mode == MD_OVER));
      checkOutput("cmp_tx_valid", int'(tx_valid), int'(m_mode == MD_HANDOFF || m_mode == MD_LOSE));
      if (m_mode == MD_HANDOFF || m_mode == MD_LOSE) begin
        checkOutput("cmp_tx_y", int'(tx_y), m_y);
        checkOutput("cmp_tx_vy", int'($signed(tx_vy)), m_vy);
        checkOutput("cmp_tx_grav", int'(tx_grav), m_grav);
        checkOutput("cmp_tx_lvl", int'(tx_lvl), m_lvl);
        checkOutput("cmp_tx_lose", int'(tx_lose), int'(m_mode == MD_LOSE));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_25MHZ);
  endtask

  task automatic applyStimulus(input logic [9:0] y, input logic [7:0] vy,
                               input logic [GW-1:0] grav, input logic [2:0] lvl, input logic win);
    rx_y = y; rx_vy = vy; rx_grav = grav; rx_lvl = lvl; rx_win = win;
    rx_valid = 1'b1;
    @(negedge clk_25MHZ);
    rx_valid = 1'b0;
    rx_win = 1'b0;
  endtask

  task automatic pulseHit(input logic [9:0] speed);
    hit_speed = speed;
    paddle_hit = 1'b1;
    @(negedge clk_25MHZ);
    paddle_hit = 1'b0;
  endtask

  task automatic acceptTx();
    tx_ready = 1'b1;
    @(negedge clk_25MHZ);
    tx_ready = 1'b0;
  endtask

  task automatic waitForTx(input int limit, input string name);
    int n;
    n = 0;
    while (tx_valid !== 1'b1 && n < limit) begin
      @(negedge clk_25MHZ);
      n++;
    end
    checkOutput(name, int'(tx_valid), 1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ball_x"}, int'(ball_x), 10);
    checkOutput({tag, "_ball_y"}, int'(ball_y), 80);
    checkOutput({tag, "_is_idle"}, int'(is_idle), 1);
    checkOutput({tag, "_tx_valid"}, int'(tx_valid), 0);
    checkOutput({tag, "_score"}, int'(score), 0);
    checkOutput({tag, "_game_over"}, int'(game_over), 0);
    checkOutput({tag, "_you_win"}, int'(you_win), 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; upscale = 1'b0; new_game = 1'b0; paddle_hit = 1'b0; hit_speed = '0;
    rx_valid = 1'b0; rx_y = '0; rx_vy = '0; rx_grav = '0; rx_lvl = '0; rx_win = 1'b0;
    tx_ready = 1'b0;
    n_checks = 0; n_fail = 0; check_en = 1'b0;

    waitCycles(2);
    check_en = 1'b1;
    checkResetValues("reset");
    reset_n = 1'b1;
    waitCycles(1);

    // Serve from the opponent, four slow steps, then a fast paddle return to handoff.
    applyStimulus(10'd100, 8'hFD, 2'd0, 3'd1, 1'b0);
    checkOutput("serve_moving_right", int'(moving_right), 1);
    checkOutput("serve_x", int'(ball_x), 20);
    checkOutput("serve_y", int'(ball_y), 100);
    waitCycles(16);
    checkOutput("step1_x", int'(ball_x), 28);
    checkOutput("step1_y", int'(ball_y), 97);
    waitCycles(48);
    checkOutput("step4_x", int'(ball_x), 52);
    checkOutput("step4_y", int'(ball_y), 88);
    checkOutput("model_vy_pin", m_vy, -2);
    pulseHit(10'd9);
    checkOutput("hit_moving_right", int'(moving_right), 0);
    checkOutput("hit_score", int'(score), 1);
    waitCycles(3);
    pulseHit(10'd1);
    waitForTx(100, "handoff_reached");
    checkOutput("handoff_x", int'(ball_x), 0);
    checkOutput("handoff_tx_y", int'(tx_y), 77);
    checkOutput("handoff_tx_vy", int'($signed(tx_vy)), -1);
    checkOutput("handoff_tx_grav", int'(tx_grav), 3);
    checkOutput("handoff_tx_lvl", int'(tx_lvl), 4);
    checkOutput("handoff_tx_lose", int'(tx_lose), 0);
    checkOutput("handoff_score", int'(score), 1);
    waitCycles(5);
    checkOutput("handoff_held_valid", int'(tx_valid), 1);
    checkOutput("handoff_held_y", int'(tx_y), 77);
    acceptTx();
    checkOutput("handoff_accept_idle", int'(is_idle), 1);
    checkOutput("handoff_accept_valid", int'(tx_valid), 0);

    // Opponent reports a loss.
    applyStimulus(10'd50, 8'h00, 2'd0, 3'd1, 1'b1);
    checkOutput("win_flag", int'(you_win), 1);
    checkOutput("win_stays_idle", int'(is_idle), 1);

    // Top bounce with an over-range level, then no return until the loss line.
    applyStimulus(10'd22, 8'hFB, 2'd0, 3'd7, 1'b0);
    checkOutput("win_cleared", int'(you_win), 0);
    waitCycles(2);
    checkOutput("top_bounce_y", int'(ball_y), 20);
    checkOutput("top_bounce_x", int'(ball_x), 28);
    waitCycles(2);
    checkOutput("after_bounce_y", int'(ball_y), 25);
    waitForTx(200, "lose_reached");
    checkOutput("lose_x", int'(ball_x), 300);
    checkOutput("lose_tx_lose", int'(tx_lose), 1);
    checkOutput("lose_game_over", int'(game_over), 1);
    waitCycles(2);
    acceptTx();
    checkOutput("over_game_over", int'(game_over), 1);
    checkOutput("over_tx_valid", int'(tx_valid), 0);
    applyStimulus(10'd100, 8'h00, 2'd0, 3'd1, 1'b0);
    checkOutput("over_ignores_rx", int'(is_idle), 0);
    checkOutput("over_rx_ready", int'(rx_ready), 0);
    new_game = 1'b1;
    waitCycles(1);
    new_game = 1'b0;
    checkOutput("new_game_idle", int'(is_idle), 1);
    checkOutput("new_game_score", int'(score), 0);
    checkOutput("new_game_over_clear", int'(game_over), 0);

    // Bottom clamp on the half field, level 0 promoted to 1.
    applyStimulus(10'd235, 8'd10, 2'd0, 3'd0, 1'b0);
    waitCycles(16);
    checkOutput("bottom_half_y", int'(ball_y), 239);
    checkOutput("bottom_half_x", int'(ball_x), 28);
    reset_n = 1'b0;
    waitCycles(1);
    checkResetValues("reset_run");
    reset_n = 1'b1;
    waitCycles(1);

    // Bottom clamp on the full field.
    upscale = 1'b1;
    applyStimulus(10'd475, 8'd10, 2'd0, 3'd4, 1'b0);
    waitCycles(2);
    checkOutput("bottom_full_y", int'(ball_y), 479);
    reset_n = 1'b0;
    waitCycles(1);
    reset_n = 1'b1;
    upscale = 1'b0;
    waitCycles(1);

    // Paddle hit in the very cycle the loss line is reached: the return wins.
    applyStimulus(10'd100, 8'h00, 2'd0, 3'd4, 1'b0);
    n = 0;
    while (ball_x !== 10'd300 && n < 200) begin
      @(negedge clk_25MHZ);
      n++;
    end
    checkOutput("loss_line_reached", int'(ball_x), 300);
    checkOutput("loss_line_still_right", int'(moving_right), 1);
    pulseHit(10'd2);
    checkOutput("hit_wins_left", int'(moving_right), 0);
    checkOutput("hit_wins_no_over", int'(game_over), 0);
    checkOutput("hit_wins_score", int'(score), 1);
    waitForTx(1000, "handoff2_reached");
    checkOutput("handoff2_tx_lvl", int'(tx_lvl), 2);
    checkOutput("handoff2_tx_lose", int'(tx_lose), 0);
    waitCycles(5);
    reset_n = 1'b0;
    waitCycles(1);
    checkResetValues("reset_handoff");
    reset_n = 1'b1;
    waitCycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
